// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter steering a shared 4:1 data mux.
// The winning word is registered and handed off downstream over valid/ready.
module mux_rr_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    output logic [1:0]        sel,
    output logic [3:0]        grant,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        ack,
    output logic              busy
);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        sel_q, sel_d;
    logic [3:0]        grant_q, grant_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    logic [1:0]        win;
    logic              win_vld;
    logic [DATA_W-1:0] win_data;
    logic              fire;

    // Scan downward so the requester nearest after last_q is assigned last.
    always_comb begin
        logic [1:0] idx;
        win     = 2'd0;
        win_vld = 1'b0;
        idx     = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = last_q + k[1:0];
            if (req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = d0;
        unique case (win)
            2'd0: win_data = d0;
            2'd1: win_data = d1;
            2'd2: win_data = d2;
            2'd3: win_data = d3;
        endcase
    end

    assign fire = valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        data_d  = data_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = XFER;
                    grant_d = 4'b0001 << win;
                    sel_d   = win;
                    data_d  = win_data;
                    valid_d = 1'b1;
                end
            end
            XFER: begin
                if (fire) begin
                    state_d = IDLE;
                    last_d  = sel_q;
                    grant_d = 4'b0000;
                    valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign sel       = sel_q;
    assign grant     = grant_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign ack       = grant_q & {4{fire}};
    assign busy      = (state_q == XFER);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter.
// Expected winners and words are queued at drive time and checked on output.
module tb_mux_rr_arbiter;

    localparam int DATA_W = 8;

    logic              clk;
    logic              rst;
    logic [3:0]        req;
    logic [DATA_W-1:0] d0, d1, d2, d3;
    logic [1:0]        sel;
    logic [3:0]        grant;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        ack;
    logic              busy;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [1:0]        idx;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] m_last;

    mux_rr_arbiter #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .sel       (sel),
        .grant     (grant),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ack       (ack),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dsel(input logic [1:0] i);
        case (i)
            2'd0: return d0;
            2'd1: return d1;
            2'd2: return d2;
            default: return d3;
        endcase
    endfunction

    // Reference round-robin pick: first requester after 'last', wrapping.
    function automatic logic [1:0] pick(input logic [3:0] r,
                                        input logic [1:0] last);
        logic [1:0] i;
        i = last;
        for (int k = 0; k < 4; k++) begin
            i = i + 2'd1;
            if (r[i]) return i;
        end
        return 2'd0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_last = 2'd3;
    endtask

    // Called at a negedge in IDLE: arbitrate, queue expectation, check output.
    task automatic start(input logic [3:0] r, input logic rdy);
        logic [1:0] w;
        exp_t e;
        req = r;
        out_ready = rdy;
        w = pick(r, m_last);
        sb.push_back('{idx: w, data: dsel(w)});
        @(negedge clk);
        e = sb.pop_front();
        chk("valid", 32'(out_valid), 32'd1);
        chk("busy", 32'(busy), 32'd1);
        chk("sel", 32'(sel), 32'(e.idx));
        chk("data", 32'(out_data), 32'(e.data));
        chk("grant", 32'(grant), 32'(4'b0001 << e.idx));
        chk("ack", 32'(ack), rdy ? 32'(4'b0001 << e.idx) : 32'd0);
    endtask

    task automatic finish_idle();
        @(negedge clk);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_grant", 32'(grant), 32'd0);
    endtask

    task automatic xfer(input logic [3:0] r);
        start(r, 1'b1);
        m_last = sel;
        finish_idle();
    endtask

    initial begin
        logic [1:0] exp_order[3];
        rst = 1'b1;
        req = 4'b0000;
        out_ready = 1'b0;
        d0 = 8'h00; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00;
        do_reset();

        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single transfer from requester 2
        d2 = 8'hA5;
        start(4'b0100, 1'b1);
        chk("t1_sel", 32'(sel), 32'd2);
        chk("t1_data", 32'(out_data), 32'hA5);
        chk("t1_ack", 32'(ack), 32'b0100);
        m_last = 2'd2;
        req = 4'b0000;
        finish_idle();

        // All requesting: fair 0,1,2,3 rotation
        do_reset();
        d0 = 8'h10; d1 = 8'h21; d2 = 8'h32; d3 = 8'h43;
        for (int i = 0; i < 8; i++) begin
            start(4'b1111, 1'b1);
            chk("t2_order", 32'(ack), 32'(4'b0001 << (i % 4)));
            m_last = sel;
            finish_idle();
        end

        // Pointer continues after requester 1
        req = 4'b0000;
        do_reset();
        xfer(4'b0010);
        exp_order[0] = 2'd3;
        exp_order[1] = 2'd0;
        exp_order[2] = 2'd1;
        for (int i = 0; i < 3; i++) begin
            start(4'b1011, 1'b1);
            chk("t3_sel", 32'(sel), 32'(exp_order[i]));
            m_last = sel;
            finish_idle();
        end

        // Stall: data frozen, withdrawal tolerated
        d0 = 8'h3C;
        start(4'b0001, 1'b0);
        d0 = 8'hFF;
        req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_data", 32'(out_data), 32'h3C);
            chk("t4_valid", 32'(out_valid), 32'd1);
            chk("t4_grant", 32'(grant), 32'b0001);
            chk("t4_noack", 32'(ack), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("t4_ack", 32'(ack), 32'b0001);
        m_last = 2'd0;
        finish_idle();
        chk("t4_ack_gone", 32'(ack), 32'd0);

        // Reset mid-transfer
        start(4'b1111, 1'b0);
        chk("t5_pre_sel", 32'(sel), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_grant", 32'(grant), 32'd0);
        chk("t5_sel", 32'(sel), 32'd0);
        chk("t5_ack", 32'(ack), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        m_last = 2'd3;
        start(4'b1111, 1'b1);
        chk("t5_first", 32'(sel), 32'd0);
        m_last = sel;
        req = 4'b0000;
        finish_idle();

        // Idle after transfer from 3: sel holds
        xfer(4'b1000);
        req = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t6_sel", 32'(sel), 32'd3);
            chk("t6_valid", 32'(out_valid), 32'd0);
            chk("t6_ack", 32'(ack), 32'd0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
